// File: rtl/sat_addsub_pipe_pkg.sv
// Shared ALU definitions: flag bit positions and signed saturation limits.
package sat_addsub_pipe_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 3;
  localparam int NUM_FLAGS = 4;

  // Limits are built at a fixed maximum width; callers truncate to their width.
  localparam int MAX_WIDTH = 64;

  function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
    logic [MAX_WIDTH-1:0] one;
    one = MAX_WIDTH'(1);
    return one << (width - 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
    logic [MAX_WIDTH-1:0] one;
    one = MAX_WIDTH'(1);
    return (one << (width - 1)) - one;
  endfunction

endpackage

// File: rtl/sat_addsub_pipe_if.sv
// Operand-side and result-side handshake bundle of the pipelined add/sub.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid && !ready.
interface sat_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovfl;
  logic             cout;
  logic             zero;
  logic             neg;

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready,
    output in_ready, out_valid, sum, ovfl, cout, zero, neg
  );

  modport master (
    output in_valid, a, b, sub, sat, out_ready,
    input  in_ready, out_valid, sum, ovfl, cout, zero, neg
  );
endinterface

// File: rtl/sat_addsub_pipe_cla_slice.sv
// Combinational G-bit carry-lookahead adder slice; also exposes the carry
// into its top bit so the last slice can derive signed overflow.
module sat_addsub_pipe_cla_slice #(
  parameter int G = 4
) (
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         cin,
  output logic [G-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);
  logic [G-1:0] p;
  logic [G-1:0] g;
  logic [G:0]   c;
  logic         pp;
  logic         acc;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the flat sum-of-products of generate/propagate terms.
  always_comb begin
    c    = '0;
    pp   = 1'b0;
    acc  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < G; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign sum      = p ^ c[G-1:0];
  assign cout     = c[G];
  assign c_msb_in = c[G-1];
endmodule

// File: rtl/sat_addsub_pipe.sv
// Skewed pipelined signed add/sub: one CLA slice per stage, optional
// saturation and NZVC flags on a registered, back-pressured output.
module sat_addsub_pipe
  import sat_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                clk,
  input  logic                rst,
  sat_addsub_pipe_if.slave    io
);
  localparam int STAGES = WIDTH / GROUP;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             sat_q [STAGES];
  logic             sat_d [STAGES];
  logic             v_q [STAGES];
  logic             v_d [STAGES];

  logic [GROUP-1:0] s_w  [STAGES];
  logic             co_w [STAGES];
  logic             cm_w [STAGES];

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;

  logic             adv;
  logic             accept;
  logic             ovfl_w;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] max_pos;
  logic [WIDTH-1:0] min_neg;

  assign max_pos = WIDTH'(sat_max(WIDTH));
  assign min_neg = WIDTH'(sat_min(WIDTH));

  assign adv         = !out_valid_q || io.out_ready;
  assign io.in_ready = adv && !rst;
  assign accept      = io.in_valid && io.in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    sat_addsub_pipe_cla_slice #(.G(GROUP)) u_slice (
      .a        (a_q[k][k*GROUP +: GROUP]),
      .b        (b_q[k][k*GROUP +: GROUP]),
      .cin      (c_q[k]),
      .sum      (s_w[k]),
      .cout     (co_w[k]),
      .c_msb_in (cm_w[k])
    );
  end

  // Stage 0 only captures; stage k>0 holds slice k-1's finished bits and carry.
  always_comb begin
    a_d[0]   = io.a;
    b_d[0]   = io.sub ? ~io.b : io.b;
    c_d[0]   = io.sub;
    sat_d[0] = io.sat;
    v_d[0]   = accept;
    r_d[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      c_d[k]   = co_w[k-1];
      sat_d[k] = sat_q[k-1];
      v_d[k]   = v_q[k-1];
      r_d[k]   = r_q[k-1];
      r_d[k][(k-1)*GROUP +: GROUP] = s_w[k-1];
    end
  end

  // Output data only changes when a real result arrives, so bubbles keep it stable.
  always_comb begin
    raw = r_q[STAGES-1];
    raw[(STAGES-1)*GROUP +: GROUP] = s_w[STAGES-1];
    ovfl_w      = cm_w[STAGES-1] ^ co_w[STAGES-1];
    out_valid_d = v_q[STAGES-1];
    sum_d       = sum_q;
    flags_d     = flags_q;
    if (v_q[STAGES-1]) begin
      sum_d = raw;
      if (sat_q[STAGES-1] && ovfl_w) begin
        sum_d = raw[WIDTH-1] ? max_pos : min_neg;
      end
      flags_d         = '0;
      flags_d[FLAG_Z] = (sum_d == '0);
      flags_d[FLAG_N] = sum_d[WIDTH-1];
      flags_d[FLAG_V] = ovfl_w;
      flags_d[FLAG_C] = co_w[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sat_q[k] <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      c_q         <= c_d;
      sat_q       <= sat_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_q;
  assign io.ovfl      = flags_q[FLAG_V];
  assign io.cout      = flags_q[FLAG_C];
  assign io.zero      = flags_q[FLAG_Z];
  assign io.neg       = flags_q[FLAG_N];
endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Directed bench for the pipelined saturating add/sub (16/4 and 8/2 builds).
// Expected words are {sum, V, C, Z, N}.
module tb_sat_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sat_addsub_pipe_if #(.WIDTH(16)) io16 ();
  sat_addsub_pipe_if #(.WIDTH(8))  io8 ();

  sat_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .io(io16.slave));
  sat_addsub_pipe #(.WIDTH(8),  .GROUP(2)) dut8  (.clk(clk), .rst(rst), .io(io8.slave));

  int n_vec  = 0;
  int n_fail = 0;
  bit timed  = 1'b0;

  logic [19:0] exp_q[$];
  int          due_q[$];
  logic [11:0] exp8_q[$];
  int          due8_q[$];

  logic [19:0] mon_e;
  int          mon_d;
  logic [11:0] mon8_e;
  int          mon8_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a result transfers.
  always @(negedge clk) begin
    if (!rst && io16.out_valid && io16.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL out16_unexpected: got sum %h, expected no result (cycle %0d)", io16.sum, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = due_q.pop_front();
        check("out16", 32'({io16.sum, io16.ovfl, io16.cout, io16.zero, io16.neg}), 32'(mon_e));
        if (mon_d >= 0) check("lat16", 32'(cyc), 32'(mon_d));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && io8.out_valid && io8.out_ready) begin
      if (exp8_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL out8_unexpected: got sum %h, expected no result (cycle %0d)", io8.sum, cyc);
      end else begin
        mon8_e = exp8_q.pop_front();
        mon8_d = due8_q.pop_front();
        check("out8", 32'({io8.sum, io8.ovfl, io8.cout, io8.zero, io8.neg}), 32'(mon8_e));
        if (mon8_d >= 0) check("lat8", 32'(cyc), 32'(mon8_d));
      end
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic sat, input logic [19:0] e);
    int guard;
    io16.in_valid = 1'b1;
    io16.a = a; io16.b = b; io16.sub = sub; io16.sat = sat;
    @(negedge clk);
    guard = 0;
    while (!io16.in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!io16.in_ready) begin
      io16.in_valid = 1'b0;
      check("send16_ready", 32'(io16.in_ready), 32'd1);
    end else begin
      exp_q.push_back(e);
      due_q.push_back(timed ? cyc + 5 : -1);
    end
    @(posedge clk); #1;
    io16.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic sat, input logic [11:0] e);
    int guard;
    io8.in_valid = 1'b1;
    io8.a = a; io8.b = b; io8.sub = sub; io8.sat = sat;
    @(negedge clk);
    guard = 0;
    while (!io8.in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!io8.in_ready) begin
      io8.in_valid = 1'b0;
      check("send8_ready", 32'(io8.in_ready), 32'd1);
    end else begin
      exp8_q.push_back(e);
      due8_q.push_back(timed ? cyc + 5 : -1);
    end
    @(posedge clk); #1;
    io8.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0/0", exp_q.size(), exp8_q.size());
      exp_q.delete(); due_q.delete(); exp8_q.delete(); due8_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    io16.in_valid = 1'b0; io16.a = '0; io16.b = '0; io16.sub = 1'b0; io16.sat = 1'b0;
    io16.out_ready = 1'b1;
    io8.in_valid = 1'b0; io8.a = '0; io8.b = '0; io8.sub = 1'b0; io8.sat = 1'b0;
    io8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst16", 32'({io16.in_ready, io16.out_valid, io16.sum, io16.ovfl, io16.cout, io16.zero, io16.neg}), 32'd0);
    check("rst8",  32'({io8.in_ready, io8.out_valid, io8.sum, io8.ovfl, io8.cout, io8.zero, io8.neg}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Saturation corners and the 8 back-to-back ops, all timed.
    timed = 1'b1;
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 4'b1000});
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b1001});
    send16(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 4'b1101});
    send16(16'h0005, 16'h0005, 1'b1, 1'b1, {16'h0000, 4'b0110});
    send16(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 4'b0000});
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b1, {16'h0000, 4'b0110});
    send16(16'h8000, 16'h8000, 1'b0, 1'b1, {16'h8000, 4'b1101});
    send16(16'h8000, 16'h8000, 1'b0, 1'b0, {16'h0000, 4'b1110});
    send16(16'h0003, 16'h0007, 1'b1, 1'b0, {16'hFFFC, 4'b0001});
    send16(16'h7000, 16'h9000, 1'b1, 1'b1, {16'h7FFF, 4'b1000});
    send16(16'h7000, 16'h9000, 1'b1, 1'b0, {16'hE000, 4'b1001});
    send16(16'hABCD, 16'hABCD, 1'b1, 1'b1, {16'h0000, 4'b0110});
    wait_drain();

    // Back-pressure: fill the pipe with the consumer stalled.
    timed = 1'b0;
    io16.out_ready = 1'b0;
    send16(16'h0001, 16'h0001, 1'b0, 1'b0, {16'h0002, 4'b0000});
    send16(16'hFFFE, 16'hFFFE, 1'b0, 1'b0, {16'hFFFC, 4'b0101});
    send16(16'h4000, 16'h4000, 1'b0, 1'b1, {16'h7FFF, 4'b1000});
    send16(16'hC000, 16'hC000, 1'b0, 1'b1, {16'h8000, 4'b0101});
    send16(16'h0000, 16'h0000, 1'b1, 1'b0, {16'h0000, 4'b0110});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold16", 32'({io16.in_ready, io16.out_valid, io16.sum, io16.ovfl, io16.cout, io16.zero, io16.neg}),
            32'({1'b0, 1'b1, 16'h0002, 4'b0000}));
      @(posedge clk); #1;
    end
    io16.out_ready = 1'b1;
    send16(16'h00FF, 16'h0F01, 1'b0, 1'b0, {16'h1000, 4'b0000});
    send16(16'h0010, 16'h0020, 1'b1, 1'b1, {16'hFFF0, 4'b0001});
    send16(16'h8001, 16'h7FFF, 1'b1, 1'b0, {16'h0002, 4'b1100});
    wait_drain();

    // Reset with three ops in flight; nothing of them may emerge.
    send16(16'h1234, 16'h4321, 1'b0, 1'b0, {16'h5555, 4'b0000});
    send16(16'h0003, 16'h0007, 1'b1, 1'b0, {16'hFFFC, 4'b0001});
    send16(16'hABCD, 16'hABCD, 1'b1, 1'b1, {16'h0000, 4'b0110});
    rst = 1'b1;
    exp_q.delete(); due_q.delete();
    io16.in_valid = 1'b1; io16.a = 16'h0001; io16.b = 16'h0001; io16.sub = 1'b0; io16.sat = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(io16.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    io16.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst16", 32'({io16.out_valid, io16.sum, io16.ovfl, io16.cout, io16.zero, io16.neg}), 32'd0);
    @(posedge clk); #1;
    timed = 1'b1;
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, {16'h3333, 4'b0000});
    repeat (8) @(posedge clk);
    #1;
    wait_drain();

    // Narrow build, same 4-cycle latency.
    send8(8'h80, 8'h80, 1'b0, 1'b1, {8'h80, 4'b1101});
    send8(8'h7F, 8'h01, 1'b0, 1'b1, {8'h7F, 4'b1000});
    send8(8'h05, 8'h05, 1'b1, 1'b0, {8'h00, 4'b0110});
    wait_drain();
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sat_addsub_pipe.md
Name: sat_addsub_pipe

Overview:
- Parametrised, pipelined signed adder/subtractor with per-operation saturate/wrap mode and NZVC flags. Next-generation replacement for the fixed 16-bit combinational saturating add/sub.
- Splits the WIDTH-bit carry chain into GROUP-bit carry-lookahead slices, one slice per pipeline stage, for full throughput at a higher clock rate.
- Sits between the ALU operand muxes and the ALU result/flag writeback, with valid/ready on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP and at least 2*GROUP.
- GROUP, 4, bits resolved per pipeline stage (CLA slice width).
- STAGES (localparam), WIDTH/GROUP, pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation present on a/b/sub/sat
- in_ready  out  1  block accepts operation this cycle
- a  in  WIDTH  operand A, two's complement
- b  in  WIDTH  operand B, two's complement
- sub  in  1  1 = A-B, 0 = A+B
- sat  in  1  1 = saturate on signed overflow, 0 = wrap
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result (saturated or wrapped)
- ovfl  out  1  signed overflow of the unsaturated result (V)
- cout  out  1  carry out of MSB (C; for sub, 1 = no borrow)
- zero  out  1  final sum == 0 (Z)
- neg  out  1  final sum[WIDTH-1] (N)

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits cleared. out_valid=0, sum=0, ovfl=0, cout=0, zero=0, neg=0. Any in-flight operation is discarded. Ops presented during the reset cycle are not accepted.
- Global advance: adv = !out_valid || out_ready. Then in_ready = adv and rst=0. The whole pipe shifts only when adv=1; otherwise every stage holds, including the output registers.
- Accept: in_valid && in_ready. Stage 0 captures a and b' = sub ? ~b : b, with carry-in = sub.
- Stage k (0..STAGES-1): computes result bits [k*GROUP +: GROUP] from the carried operand slices and the registered carry from stage k-1.
  - Upper operand bits travel forward unconsumed (skewed pipeline).
  - Lower result bits travel forward already finished.
- Final stage also computes:
  - c_msb_in = carry into bit WIDTH-1; cout = carry out of bit WIDTH-1.
  - ovfl = c_msb_in XOR cout.
  - raw = wrapped sum.
  - If sat && ovfl: sum = raw[WIDTH-1] ? {0,1...1} (max positive) : {1,0...0} (min negative). Otherwise sum = raw.
  - zero and neg are computed from the final sum, so a saturated result gives zero=0.
- Latency: exactly STAGES cycles from the accept edge to out_valid, with no stalls. Throughput: one op per cycle. A bubble (in_valid=0 while adv=1) propagates as an invalid stage.
- Hold rule: while out_valid && !out_ready, sum and all flags stay stable, and in_ready=0.
- Simultaneous accept at input and drain at output in one cycle is legal; no lost or duplicated ops.
- Outputs are registered; no combinational path from a/b to sum. The only combinational paths are out_ready -> in_ready.
- Ops complete in accept order.

Decomposition:
- Shared ALU package holds:
  - flag-index constants (FLAG_Z, FLAG_V, FLAG_N, FLAG_C);
  - the saturation-limit functions sat_max(WIDTH) and sat_min(WIDTH).
- One sub-module: cla_slice, a combinational GROUP-bit carry-lookahead adder.
  - Inputs: a, b, cin. Outputs: sum, cout, c_msb_in (carry into its top bit).
  - Instantiated once per stage; only the last instance's c_msb_in is used.

Test Plan:
- WIDTH=16, GROUP=4, out_ready=1: a=0x7FFF, b=0x0001, sub=0, sat=1. Expect 4 cycles later sum=0x7FFF, ovfl=1, cout=0, zero=0, neg=0. Same with sat=0: expect sum=0x8000, ovfl=1, neg=1.
- a=0x8000, b=0x0001, sub=1, sat=1: expect sum=0x8000, ovfl=1. Then a=0x0005, b=0x0005, sub=1: expect sum=0x0000, zero=1, cout=1, ovfl=0.
- Eight back-to-back random ops with in_valid=1 and out_ready=1: expect in_ready=1 throughout, results on 8 consecutive cycles starting 4 cycles after the first accept, all matching the reference model in order.
- Pipe full, out_ready=0 for 3 cycles: expect in_ready=0, sum and flags unchanged for those cycles. Release: expect remaining ops to drain in order, with no loss or duplication.
- rst=1 for one cycle with 3 ops in flight: expect out_valid=0 and all outputs 0 the next cycle, no stale results afterwards, and a fresh op's result 4 cycles after its accept.
- WIDTH=8, GROUP=2 instance: a=0x80, b=0x80, sub=0, sat=1. Expect sum=0x80, ovfl=1, cout=1, after a latency of 4 cycles.
